// File: rtl/dpram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// dpram_fifo_ctrl
//
// Show-ahead FIFO controller wrapped around an external 1024x18 dual-port RAM
// with synchronous read-through. The controller owns the write/read pointers,
// the occupancy count and the watermark flags. It produces the RAM write port
// and the RAM read address. The RAM output is passed straight through as the
// head of the FIFO.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset
//   flush         synchronous clear of all FIFO contents
//   in_valid      write request from the upstream producer
//   in_ready      FIFO can accept a word (not full and not flushing)
//   in_data       write data
//   out_valid     head word is valid (FIFO not empty)
//   out_ready     downstream consumer takes the head word
//   out_data      head word, taken directly from ram_dpo
//   ram_we        RAM write enable (a push this cycle)
//   ram_a         RAM write address (write pointer)
//   ram_di        RAM write data (in_data)
//   ram_dpra      RAM read address (read pointer after this cycle's pop)
//   ram_dpo       RAM read data for the address captured at the last edge
//   level         registered occupancy, 0..DEPTH
//   almost_full   registered flag, level >= AFULL_TH
//   almost_empty  registered flag, level <= AEMPTY_TH
// ---------------------------------------------------------------------------
module dpram_fifo_ctrl #(
    parameter int DATA_W    = 18,
    parameter int ADDR_W    = 10,
    parameter int AFULL_TH  = 1008,
    parameter int AEMPTY_TH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_di,
    output logic [ADDR_W-1:0] ram_dpra,
    input  logic [DATA_W-1:0] ram_dpo,
    output logic [ADDR_W:0]   level,
    output logic              almost_full,
    output logic              almost_empty
);

    localparam int            DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_LVL  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_LVL  = (ADDR_W + 1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_LVL = (ADDR_W + 1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0] LVL_ONE    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_ptr_next;
    logic [ADDR_W:0]   level_next;
    logic              push;
    logic              pop;

    // Handshakes. Readiness is blocked while flushing so a flush cycle can
    // never store a word; valid comes straight from the registered level.
    assign in_ready  = (level != DEPTH_LVL) && !flush;
    assign out_valid = (level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // The RAM captures the read address at the edge, so presenting the
    // post-pop pointer now makes ram_dpo hold the new head right after the
    // edge. Pointers wrap naturally at DEPTH because of their width.
    assign rd_ptr_next = pop ? (rd_ptr + PTR_ONE) : rd_ptr;

    assign ram_we   = push;
    assign ram_a    = wr_ptr;
    assign ram_di   = in_data;
    assign ram_dpra = rd_ptr_next;
    assign out_data = ram_dpo;

    // Next occupancy. The ready/valid gating keeps this inside 0..DEPTH, so
    // no saturation is required.
    always_comb begin
        level_next = level;
        if (flush) begin
            level_next = '0;
        end else if (push && !pop) begin
            level_next = level + LVL_ONE;
        end else if (pop && !push) begin
            level_next = level - LVL_ONE;
        end
    end

    // Pointer, level and watermark registers. Watermarks are derived from the
    // next level so they move on the same edge as the level itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                rd_ptr <= rd_ptr_next;
            end
            level        <= level_next;
            almost_full  <= (level_next >= AFULL_LVL);
            almost_empty <= (level_next <= AEMPTY_LVL);
        end
    end

endmodule
